wb_result_checker: RTL and testbench
====================================

Name: wb_result_checker

Overview:
Synthesizable result checker that sits directly downstream of the CPU register-file write-back port inside the SoC test harness. It holds a programmed sequence of expected (rd, value) commits and compares them in order against live write-backs. It reports pass, fail or timeout on sticky status outputs, so directed programs self-check without reading register contents hierarchically.

Parameters:
DEPTH, 4, number of expected-commit entries (power of 2, 2..16)
TIMEOUT_CYCLES, 1000, cycles allowed in RUN before TIMEOUT (≥1)
CW, 16, width of the cycle counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  write expected entry at cfg_idx (ignored outside IDLE)
cfg_idx  in  log2(DEPTH)  entry index
cfg_rd  in  5  expected destination register
cfg_val  in  32  expected write data
cfg_num  in  log2(DEPTH)+1  number of valid entries, sampled on start
start  in  1  single-cycle pulse: IDLE->RUN
wb_en  in  1  register-file write enable from CPU write-back
wb_rd  in  5  write-back destination register
wb_data  in  32  write-back data
busy  out  1  high in RUN
done  out  1  sticky, high in PASS/FAIL/TIMEOUT
pass  out  1  sticky, high only in PASS
fail_idx  out  log2(DEPTH)  entry index at mismatch/timeout
fail_data  out  32  offending wb_data (0 on timeout)
cycles  out  CW  cycles spent in RUN, frozen at completion

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, pass=0, fail_idx=0, fail_data=0, cycles=0, ptr=0. Table contents are cleared to 0.
- IDLE: cfg_we writes {cfg_rd,cfg_val} to entry cfg_idx on the clock edge. On start, latch num=cfg_num and clear ptr/cycles. If num==0, go directly to PASS on the next edge; otherwise go to RUN.
- RUN: cycles increments every cycle. A write-back is "qualifying" when wb_en=1 and wb_rd!=0; writes to x0 are ignored.
  - Qualifying write with wb_rd==entry[ptr].rd:
    - wb_data==entry[ptr].val -> ptr++. If ptr+1==num -> PASS.
    - Otherwise -> FAIL, fail_idx=ptr, fail_data=wb_data.
  - Qualifying write to any other rd: ignored, no state change.
  - Timeout: cycles reaching TIMEOUT_CYCLES-1 with no completion -> TIMEOUT, fail_idx=ptr, fail_data=0. A match/mismatch in that same cycle takes priority over timeout.
- Completion latency: status registers update on the edge that samples the deciding write-back. done/pass are visible the following cycle.
- PASS/FAIL/TIMEOUT: terminal and sticky; done=1, busy=0; all inputs except start are ignored. start returns to IDLE with status cleared, and the table is retained for reuse.
- start while in RUN: ignored.
- cfg_we in a non-IDLE state: ignored; the table is unchanged.
- cfg_num>DEPTH: clamped to DEPTH.
- Only one write-back per cycle; no buffering needed. wb_* are sampled combinationally and compared in the same cycle.

Test Plan:
1. Program {x27=5, x28=7, x29=12}, num=3, start. Drive wb x27=5, x28=7, x29=12 interleaved with writes to x1/x0 -> PASS; done=1, pass=1, cycles equals elapsed cycles.
2. Same table, drive x28=8 as the second match -> FAIL; fail_idx=1, fail_data=8, pass=0.
3. Table loaded, no write-backs for TIMEOUT_CYCLES -> TIMEOUT; done=1, pass=0, fail_data=0, cycles=TIMEOUT_CYCLES.
4. num=0 then start -> PASS within 1 cycle. cfg_we during RUN -> table readback via a later run is unchanged.
5. Assert rst mid-RUN after one match -> all outputs 0 immediately (async). A fresh program and start then passes.
6. Final matching write and timeout in the same cycle -> PASS. After done, start -> IDLE, done=0; rerun with the same table passes.

Source files
------------

// File: rtl/wb_result_checker.sv
// -----------------------------------------------------------------------------
// wb_result_checker
//
// Sits on the CPU register-file write-back port. It holds a programmed list of
// expected (rd, value) commits and checks live write-backs against that list,
// in order. The outcome (pass, fail or timeout) is reported on sticky status
// outputs.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   cfg_we     write {cfg_rd, cfg_val} into entry cfg_idx (IDLE only)
//   cfg_idx    entry index
//   cfg_rd     expected destination register
//   cfg_val    expected write data
//   cfg_num    number of valid entries, sampled on start (clamped to DEPTH)
//   start      pulse: IDLE->RUN, or terminal->IDLE
//   wb_en      register-file write enable
//   wb_rd      write-back destination register
//   wb_data    write-back data
//   busy       high while running
//   done       sticky, high in PASS/FAIL/TIMEOUT
//   pass       sticky, high only in PASS
//   fail_idx   entry index at mismatch/timeout
//   fail_data  offending wb_data (0 on timeout)
//   cycles     cycles spent in RUN, frozen at completion
// -----------------------------------------------------------------------------
module wb_result_checker #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CW             = 16,
    localparam int IW            = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [4:0]    cfg_rd,
    input  logic [31:0]   cfg_val,
    input  logic [IW:0]   cfg_num,
    input  logic          start,
    input  logic          wb_en,
    input  logic [4:0]    wb_rd,
    input  logic [31:0]   wb_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [IW-1:0] fail_idx,
    output logic [31:0]   fail_data,
    output logic [CW-1:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW:0]   num;
    logic [4:0]    tbl_rd  [DEPTH];
    logic [31:0]   tbl_val [DEPTH];

    logic        qual;
    logic        hit;
    logic        match;
    logic        last;
    logic        tmo;
    logic [IW:0] num_clamped;

    // Writes to x0 never retire architecturally, so they never qualify.
    assign qual  = wb_en && (wb_rd != 5'd0);
    assign hit   = qual && (wb_rd == tbl_rd[ptr]);
    assign match = hit && (wb_data == tbl_val[ptr]);
    assign last  = (({1'b0, ptr} + {{IW{1'b0}}, 1'b1}) == num);
    // The deciding RUN cycle also counts, so cycles reads TIMEOUT_CYCLES on expiry.
    assign tmo   = (cycles == CW'(TIMEOUT_CYCLES - 1));

    assign num_clamped = (cfg_num > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : cfg_num;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            num       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_idx  <= '0;
            fail_data <= '0;
            cycles    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_rd[i]  <= '0;
                tbl_val[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        tbl_rd[cfg_idx]  <= cfg_rd;
                        tbl_val[cfg_idx] <= cfg_val;
                    end
                    if (start) begin
                        num    <= num_clamped;
                        ptr    <= '0;
                        cycles <= '0;
                        if (num_clamped == '0) begin
                            state <= S_PASS;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    cycles <= cycles + CW'(1);
                    if (match) begin
                        if (last) begin
                            state <= S_PASS;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            ptr <= ptr + IW'(1);
                            // A non-final match on the expiry cycle still times
                            // out; the report names the entry still outstanding.
                            if (tmo) begin
                                state     <= S_TIMEOUT;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                fail_idx  <= ptr + IW'(1);
                                fail_data <= '0;
                            end
                        end
                    end else if (hit) begin
                        state     <= S_FAIL;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail_idx  <= ptr;
                        fail_data <= wb_data;
                    end else if (tmo) begin
                        state     <= S_TIMEOUT;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail_idx  <= ptr;
                        fail_data <= '0;
                    end
                end

                default: begin
                    // Terminal states hold everything; the table survives the
                    // return to IDLE so the same program can be rerun.
                    if (start) begin
                        state     <= S_IDLE;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_idx  <= '0;
                        fail_data <= '0;
                        cycles    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_result_checker.sv
module tb_wb_result_checker;

    localparam int DEPTH = 4;
    localparam int T     = 40;
    localparam int CW    = 8;
    localparam int IW    = 2;
    localparam int SL    = T + 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [4:0]    cfg_rd;
    logic [31:0]   cfg_val;
    logic [IW:0]   cfg_num;
    logic          start;
    logic          wb_en;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          busy;
    logic          done;
    logic          pass;
    logic [IW-1:0] fail_idx;
    logic [31:0]   fail_data;
    logic [CW-1:0] cycles;

    wb_result_checker #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(T), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_rd(cfg_rd), .cfg_val(cfg_val),
        .cfg_num(cfg_num), .start(start),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy), .done(done), .pass(pass),
        .fail_idx(fail_idx), .fail_data(fail_data), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference table as the bench believes it was programmed.
    logic [4:0]  m_rd  [DEPTH];
    logic [31:0] m_val [DEPTH];

    // Write-back stream, one slot per RUN cycle.
    logic        s_en  [SL];
    logic [4:0]  s_rd  [SL];
    logic [31:0] s_dat [SL];
    bit          cfg_noise = 0;

    // Observed after a run.
    logic        o_done, o_pass, o_busy_run;
    logic [31:0] o_idx, o_data;
    int          o_cycles, o_cycles_late, o_elapsed;

    // Expected from the model.
    logic        e_pass;
    logic [31:0] e_idx, e_data;
    int          e_cycles;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stream();
        for (int i = 0; i < SL; i++) begin
            s_en[i] = 0; s_rd[i] = '0; s_dat[i] = '0;
        end
    endtask

    task automatic put(input int c, input logic [4:0] rd, input logic [31:0] d);
        s_en[c] = 1; s_rd[c] = rd; s_dat[c] = d;
    endtask

    task automatic program_entry(input int idx, input logic [4:0] rd, input logic [31:0] val);
        cfg_we = 1; cfg_idx = IW'(idx); cfg_rd = rd; cfg_val = val;
        tick();
        cfg_we = 0;
        m_rd[idx] = rd; m_val[idx] = val;
    endtask

    task automatic to_idle();
        start = 1;
        tick();
        start = 0;
    endtask

    // Walks the stream against the expected list in order: the first write
    // to the awaited register decides match or mismatch; nothing decisive
    // within T cycles means timeout.
    task automatic model(input int num_in);
        int n;
        int p;
        n = (num_in > DEPTH) ? DEPTH : num_in;
        p = 0;
        e_pass = 0; e_idx = 0; e_data = 0; e_cycles = T;
        if (n == 0) begin
            e_pass = 1; e_cycles = 0;
            return;
        end
        for (int c = 0; c < T; c++) begin
            if (s_en[c] && s_rd[c] != 0 && s_rd[c] == m_rd[p]) begin
                if (s_dat[c] == m_val[p]) begin
                    p++;
                    if (p == n) begin
                        e_pass = 1; e_cycles = c + 1;
                        return;
                    end
                end else begin
                    e_idx = p; e_data = s_dat[c]; e_cycles = c + 1;
                    return;
                end
            end
        end
        e_idx = p;
    endtask

    task automatic noise_cfg();
        cfg_we  = cfg_noise;
        cfg_idx = IW'($urandom_range(0, DEPTH - 1));
        cfg_rd  = 5'($urandom_range(1, 31));
        cfg_val = $urandom;
    endtask

    // Starts a run from IDLE, plays the stream until done (bounded), then
    // plays two more cycles of junk to see that status stays frozen.
    task automatic run_stream(input int num_in);
        int c;
        cfg_num = (IW+1)'(num_in);
        start = 1;
        tick();
        start = 0;
        cfg_num = (IW+1)'($urandom);
        o_busy_run = busy;
        c = 0;
        while (!done && c < SL) begin
            wb_en = s_en[c]; wb_rd = s_rd[c]; wb_data = s_dat[c];
            noise_cfg();
            tick();
            c++;
        end
        wb_en = 0; cfg_we = 0;
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL run_bound: done=%0b after %0d cycles, required 1", done, c);
        end
        o_elapsed = c;
        o_done = done; o_pass = pass;
        o_idx = 32'(fail_idx); o_data = fail_data; o_cycles = int'(cycles);
        for (int k = 0; k < 2; k++) begin
            wb_en = 1; wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
            noise_cfg();
            tick();
        end
        wb_en = 0; cfg_we = 0;
        o_cycles_late = int'(cycles);
    endtask

    task automatic load_basic();
        program_entry(0, 5'd27, 32'd5);
        program_entry(1, 5'd28, 32'd7);
        program_entry(2, 5'd29, 32'd12);
    endtask

    task automatic stream_basic_pass();
        clear_stream();
        put(0, 5'd1, 32'd99);
        put(1, 5'd27, 32'd5);
        put(2, 5'd0, 32'd7);
        put(3, 5'd28, 32'd7);
        put(5, 5'd1, 32'd3);
        put(6, 5'd29, 32'd12);
    endtask

    task automatic test_reset();
        rst = 1;
        #12;
        n_cmp++;
        if ({busy, done, pass, fail_idx, fail_data, cycles} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got b%0b d%0b p%0b idx%0h data%0h cyc%0h, required all 0",
                     busy, done, pass, fail_idx, fail_data, cycles);
        end
        rst = 0;
        for (int i = 0; i < DEPTH; i++) begin m_rd[i] = '0; m_val[i] = '0; end
        tick();
    endtask

    task automatic test_pass();
        load_basic();
        stream_basic_pass();
        run_stream(3);
        n_cmp++;
        if (o_busy_run !== 1'b1) begin n_err++; $display("FAIL pass_busy: got %0b required 1", o_busy_run); end
        n_cmp++;
        if ({o_done, o_pass} !== 2'b11) begin n_err++; $display("FAIL pass_status: done/pass got %b required 11", {o_done, o_pass}); end
        n_cmp++;
        if (o_cycles !== 7) begin n_err++; $display("FAIL pass_cycles: got %0d required 7", o_cycles); end
        n_cmp++;
        if (o_cycles_late !== 7) begin n_err++; $display("FAIL pass_cycles_frozen: got %0d required 7", o_cycles_late); end
        to_idle();
    endtask

    task automatic test_fail();
        clear_stream();
        put(0, 5'd27, 32'd5);
        put(1, 5'd28, 32'd8);
        run_stream(3);
        n_cmp++;
        if ({o_done, o_pass} !== 2'b10) begin n_err++; $display("FAIL fail_status: done/pass got %b required 10", {o_done, o_pass}); end
        n_cmp++;
        if (o_idx !== 1) begin n_err++; $display("FAIL fail_idx: got %0d required 1", o_idx); end
        n_cmp++;
        if (o_data !== 8) begin n_err++; $display("FAIL fail_data: got %0d required 8", o_data); end
        n_cmp++;
        if (o_cycles !== 2) begin n_err++; $display("FAIL fail_cycles: got %0d required 2", o_cycles); end
        to_idle();
    endtask

    task automatic test_timeout();
        clear_stream();
        put(3, 5'd28, 32'd7);
        run_stream(3);
        n_cmp++;
        if ({o_done, o_pass} !== 2'b10) begin n_err++; $display("FAIL tmo_status: done/pass got %b required 10", {o_done, o_pass}); end
        n_cmp++;
        if (o_data !== 0 || o_idx !== 0) begin n_err++; $display("FAIL tmo_fields: idx %0d data %0h required 0/0", o_idx, o_data); end
        n_cmp++;
        if (o_cycles !== T || o_cycles_late !== T) begin
            n_err++; $display("FAIL tmo_cycles: got %0d/%0d required %0d", o_cycles, o_cycles_late, T);
        end
        to_idle();
    endtask

    task automatic test_num_zero_and_cfg_lock();
        clear_stream();
        run_stream(0);
        n_cmp++;
        if ({o_done, o_pass, o_busy_run} !== 3'b110) begin
            n_err++; $display("FAIL num0_status: done/pass/busy got %b required 110", {o_done, o_pass, o_busy_run});
        end
        n_cmp++;
        if (o_cycles !== 0) begin n_err++; $display("FAIL num0_cycles: got %0d required 0", o_cycles); end
        to_idle();
        // Table writes attempted during RUN and in PASS must be dropped.
        cfg_noise = 1;
        stream_basic_pass();
        run_stream(3);
        cfg_noise = 0;
        n_cmp++;
        if (o_pass !== 1'b1) begin n_err++; $display("FAIL cfg_lock_run: pass got %0b required 1", o_pass); end
        to_idle();
        run_stream(3);
        n_cmp++;
        if (o_pass !== 1'b1 || o_cycles !== 7) begin
            n_err++; $display("FAIL cfg_lock_rerun: pass %0b cycles %0d required 1/7", o_pass, o_cycles);
        end
        to_idle();
    endtask

    task automatic test_clamp();
        program_entry(3, 5'd30, 32'hDEAD_BEEF);
        clear_stream();
        put(0, 5'd27, 32'd5);
        put(1, 5'd28, 32'd7);
        put(2, 5'd29, 32'd12);
        put(4, 5'd30, 32'hDEAD_BEEF);
        run_stream(7);
        n_cmp++;
        if (o_pass !== 1'b1 || o_cycles !== 5) begin
            n_err++; $display("FAIL clamp: pass %0b cycles %0d required 1/5", o_pass, o_cycles);
        end
        to_idle();
    endtask

    task automatic test_reset_mid_run();
        cfg_num = 3'd3;
        start = 1;
        tick();
        start = 0;
        wb_en = 1; wb_rd = 5'd27; wb_data = 32'd5;
        tick();
        wb_en = 0;
        #3 rst = 1;
        #1;
        n_cmp++;
        if ({busy, done, pass, fail_idx, fail_data, cycles} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got b%0b d%0b p%0b idx%0h data%0h cyc%0h, required all 0",
                     busy, done, pass, fail_idx, fail_data, cycles);
        end
        #1 rst = 0;
        for (int i = 0; i < DEPTH; i++) begin m_rd[i] = '0; m_val[i] = '0; end
        tick();
        // The cleared table must no longer recognise the old program.
        clear_stream();
        put(0, 5'd27, 32'd5);
        put(1, 5'd28, 32'd7);
        model(1);
        run_stream(1);
        n_cmp++;
        if (o_pass !== e_pass || o_cycles !== e_cycles) begin
            n_err++; $display("FAIL reset_table_cleared: pass %0b cycles %0d required %0b/%0d", o_pass, o_cycles, e_pass, e_cycles);
        end
        to_idle();
        program_entry(0, 5'd3, 32'h1234);
        program_entry(1, 5'd4, 32'h5678);
        clear_stream();
        put(2, 5'd3, 32'h1234);
        put(4, 5'd4, 32'h5678);
        run_stream(2);
        n_cmp++;
        if (o_pass !== 1'b1 || o_cycles !== 5) begin
            n_err++; $display("FAIL reset_fresh_pass: pass %0b cycles %0d required 1/5", o_pass, o_cycles);
        end
        to_idle();
    endtask

    task automatic test_final_vs_timeout();
        program_entry(0, 5'd5, 32'hAB);
        clear_stream();
        put(T - 1, 5'd5, 32'hAB);
        run_stream(1);
        n_cmp++;
        if (o_pass !== 1'b1 || o_cycles !== T) begin
            n_err++; $display("FAIL edge_pass: pass %0b cycles %0d required 1/%0d", o_pass, o_cycles, T);
        end
        to_idle();
        clear_stream();
        put(T - 1, 5'd5, 32'hAC);
        run_stream(1);
        n_cmp++;
        if (o_pass !== 1'b0 || o_data !== 32'hAC || o_cycles !== T) begin
            n_err++; $display("FAIL edge_mismatch: pass %0b data %0h cycles %0d required 0/ac/%0d", o_pass, o_data, o_cycles, T);
        end
        start = 1;
        tick();
        start = 0;
        n_cmp++;
        if ({done, pass, busy, cycles} !== '0) begin
            n_err++; $display("FAIL back_to_idle: done %0b pass %0b busy %0b cycles %0d required 0", done, pass, busy, cycles);
        end
        clear_stream();
        put(0, 5'd5, 32'hAB);
        run_stream(1);
        n_cmp++;
        if (o_pass !== 1'b1 || o_cycles !== 1) begin
            n_err++; $display("FAIL rerun_pass: pass %0b cycles %0d required 1/1", o_pass, o_cycles);
        end
        to_idle();
    endtask

    task automatic test_random();
        for (int run = 0; run < 20; run++) begin
            int num_in;
            int n_eff;
            int g;
            int pc;
            int pw;
            for (int i = 0; i < DEPTH; i++)
                if ($urandom_range(0, 1) == 1)
                    program_entry(i, 5'($urandom_range(1, 31)), $urandom);
            num_in = $urandom_range(0, 7);
            n_eff  = (num_in > DEPTH) ? DEPTH : num_in;
            pc = ($urandom_range(0, 3) == 0) ? 4 : 35;
            pw = ($urandom_range(0, 2) == 0) ? 4 : 0;
            clear_stream();
            g = 0;
            for (int c = 0; c < T; c++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < pc && g < n_eff) begin
                    put(c, m_rd[g], m_val[g]);
                    g++;
                end else if (r < pc + pw && g < n_eff) begin
                    put(c, m_rd[g], m_val[g] ^ (32'd1 << $urandom_range(0, 31)));
                end else if (r < 60) begin
                    put(c, 5'($urandom_range(1, 31)), $urandom);
                end else if (r < 70) begin
                    put(c, 5'd0, $urandom);
                end
            end
            cfg_noise = ($urandom_range(0, 1) == 1);
            model(num_in);
            run_stream(num_in);
            cfg_noise = 0;
            n_cmp++;
            if (o_pass !== e_pass) begin
                n_err++; $display("FAIL rand%0d_pass: got %0b required %0b", run, o_pass, e_pass);
            end
            n_cmp++;
            if (o_cycles !== e_cycles || o_cycles_late !== e_cycles) begin
                n_err++; $display("FAIL rand%0d_cycles: got %0d/%0d required %0d", run, o_cycles, o_cycles_late, e_cycles);
            end
            if (!e_pass) begin
                n_cmp++;
                if (o_idx !== e_idx || o_data !== e_data) begin
                    n_err++; $display("FAIL rand%0d_fail_info: idx %0d data %0h required %0d/%0h", run, o_idx, o_data, e_idx, e_data);
                end
            end
            to_idle();
            n_cmp++;
            if (done !== 1'b0) begin
                n_err++; $display("FAIL rand%0d_idle: done got %0b required 0", run, done);
            end
        end
    endtask

    initial begin
        rst = 0; cfg_we = 0; cfg_idx = '0; cfg_rd = '0; cfg_val = '0;
        cfg_num = '0; start = 0; wb_en = 0; wb_rd = '0; wb_data = '0;
        clear_stream();
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_num_zero_and_cfg_lock();
        test_clamp();
        test_reset_mid_run();
        test_final_vs_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
